regfile_wport_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline writeback stage and long-latency producers (multiply/divide unit, load-miss return). It also keeps a busy scoreboard of registers with outstanding long-latency results, so hazard logic can stall readers. It sits between the WB stage/functional units and the register file write inputs.

---
 rtl/regfile_wport_arbiter_pkg.sv | 26 ++
 rtl/regfile_wport_arbiter_rr_arbiter.sv | 62 ++++++
 rtl/regfile_wport_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wport_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wport_arbiter_pkg
// Shared constants for the register-file write-port arbiter: requester count,
// data/address widths, the index of the writeback requester, the hard-wired
// zero register address, and a helper that decodes an address to a one-hot
// register mask for the busy scoreboard.
// -----------------------------------------------------------------------------
package regfile_wport_arbiter_pkg;

  localparam int NUM_REQ  = 3;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // Requester 0 is the pipeline writeback stage and always wins.
  localparam int REQ_WB = 0;

  // Register 0 is hard-wired; writes are swallowed and it is never busy.
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // One-hot decode of a register address into the scoreboard bit space.
  function automatic logic [NUM_REGS-1:0] addrOneHot(input logic [ADDR_W-1:0] addr);
    addrOneHot = NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_wport_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wport_arbiter_rr_arbiter
// Round-robin grant among requesters 1..NUM_REQ-1 (bit 0 of reqValid is
// ignored). The search starts at rrPtr_r and wraps from NUM_REQ-1 back to 1.
// After a grant to k, the pointer moves to k+1 (wrapping to 1).
// Ports:
//   clk      in  clock
//   reset    in  asynchronous active-high reset (pointer returns to 1)
//   enable   in  arbitration allowed this cycle (writeback idle, not in reset)
//   reqValid in  per-requester request
//   grant    out one-hot grant (combinational), bit 0 always 0
// -----------------------------------------------------------------------------
module regfile_wport_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] reqValid,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W-1:0] rrPtr_r;
  logic [PTR_W-1:0] nextPtr_s;

  // Search from the pointer for the first valid requester and derive the next pointer.
  always_comb begin : rrSearch
    logic             found;
    logic [PTR_W-1:0] idx;
    grant     = '0;
    nextPtr_s = rrPtr_r;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ - 1; off++) begin
      idx = PTR_W'(((int'(rrPtr_r) - 1 + off) % (NUM_REQ - 1)) + 1);
      if (enable && !found && reqValid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        if (idx == PTR_W'(NUM_REQ - 1)) begin
          nextPtr_s = PTR_W'(1);
        end else begin
          nextPtr_s = idx + PTR_W'(1);
        end
      end else begin
        found = found;
      end
    end
  end

  // Pointer register; only advances when a round-robin grant is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr_r <= PTR_W'(1);
    end else if (|grant) begin
      rrPtr_r <= nextPtr_s;
    end else begin
      rrPtr_r <= rrPtr_r;
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wport_arbiter
// Shares the register file's single write port between the writeback stage
// (requester 0, absolute priority) and long-latency producers (requesters
// 1..NUM_REQ-1, round-robin). Also tracks which registers await a
// long-latency result so hazard logic can stall readers.
// Ports:
//   Clk         in  clock
//   reset       in  asynchronous active-high reset
//   req_valid   in  per-requester write request
//   req_addr    in  packed destination registers (ADDR_W per requester)
//   req_data    in  packed write data (DATA_W per requester)
//   req_ready   out one-hot grant, combinational from req_valid
//   claim_valid in  long-latency op issued this cycle
//   claim_addr  in  its destination register
//   RegWrite    out registered register-file write enable
//   WriteReg    out registered write address
//   WriteData   out registered write data
//   busy_mask   out registers awaiting a long-latency result
//   claim_err   out sticky: a claim hit a register that was still busy
// -----------------------------------------------------------------------------
module regfile_wport_arbiter #(
  parameter int NUM_REQ = regfile_wport_arbiter_pkg::NUM_REQ,
  parameter int DATA_W  = regfile_wport_arbiter_pkg::DATA_W,
  parameter int ADDR_W  = regfile_wport_arbiter_pkg::ADDR_W
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_addr,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteReg,
  output logic [DATA_W-1:0]         WriteData,
  output logic [31:0]               busy_mask,
  output logic                      claim_err
);

  import regfile_wport_arbiter_pkg::*;

  logic [NUM_REQ-1:0] rrGrant_s;
  logic               rrEnable_s;
  logic               handshake_s;
  logic               fromRr_s;
  logic [ADDR_W-1:0]  selAddr_s;
  logic [DATA_W-1:0]  selData_s;
  logic [31:0]        setMask_s;
  logic [31:0]        clearMask_s;
  logic [31:0]        busyNext_s;
  logic               errHit_s;

  // Round-robin only runs when writeback is idle and reset is released.
  assign rrEnable_s = !reset && !req_valid[REQ_WB];

  regfile_wport_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (Clk),
    .reset    (reset),
    .enable   (rrEnable_s),
    .reqValid (req_valid),
    .grant    (rrGrant_s)
  );

  // Grant: writeback first, otherwise the round-robin winner; nothing during reset.
  always_comb begin
    req_ready = '0;
    if (reset) begin
      req_ready = '0;
    end else if (req_valid[REQ_WB]) begin
      req_ready[REQ_WB] = 1'b1;
    end else begin
      req_ready = rrGrant_s;
    end
  end

  // Mux the granted requester's address/data; ready implies valid, so any ready bit is a handshake.
  always_comb begin
    handshake_s = 1'b0;
    fromRr_s    = 1'b0;
    selAddr_s   = '0;
    selData_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        handshake_s = 1'b1;
        fromRr_s    = (i != REQ_WB);
        selAddr_s   = req_addr[i*ADDR_W +: ADDR_W];
        selData_s   = req_data[i*DATA_W +: DATA_W];
      end else begin
        handshake_s = handshake_s;
      end
    end
  end

  // Scoreboard next state: clear on long-latency writeback, set on claim (set wins), r0 never busy.
  always_comb begin
    if (handshake_s && fromRr_s) begin
      clearMask_s = addrOneHot(selAddr_s);
    end else begin
      clearMask_s = '0;
    end
    if (claim_valid && (claim_addr != REG_ZERO)) begin
      setMask_s = addrOneHot(claim_addr);
    end else begin
      setMask_s = '0;
    end
    busyNext_s = ((busy_mask & ~clearMask_s) | setMask_s) & ~32'h0000_0001;
    errHit_s   = |(setMask_s & busy_mask & ~clearMask_s);
  end

  // Write-port output registers; address/data hold when no handshake.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (handshake_s) begin
      RegWrite  <= (selAddr_s != REG_ZERO);
      WriteReg  <= selAddr_s;
      WriteData <= selData_s;
    end else begin
      RegWrite  <= 1'b0;
      WriteReg  <= WriteReg;
      WriteData <= WriteData;
    end
  end

  // Busy scoreboard and sticky claim error.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      busy_mask <= '0;
      claim_err <= 1'b0;
    end else begin
      busy_mask <= busyNext_s;
      claim_err <= claim_err | errHit_s;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
module tb_regfile_wport_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic                      Clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      claim_valid;
  logic [ADDR_W-1:0]         claim_addr;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         WriteReg;
  logic [DATA_W-1:0]         WriteData;
  logic [31:0]               busy_mask;
  logic                      claim_err;

  regfile_wport_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .RegWrite    (RegWrite),
    .WriteReg    (WriteReg),
    .WriteData   (WriteData),
    .busy_mask   (busy_mask),
    .claim_err   (claim_err)
  );

  always #5 Clk = ~Clk;

  int vecs = 0;
  int miss = 0;

  // Reference model state
  int          mPtr;
  logic [31:0] mBusy;
  logic        mErr;
  logic        mRegWrite;
  logic [4:0]  mWriteReg;
  logic [31:0] mWriteData;

  logic [4:0]  addrA [NUM_REQ];
  logic [31:0] dataA [NUM_REQ];

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = addrA[i];
      req_data[i*DATA_W +: DATA_W] = dataA[i];
    end
  endtask

  task automatic model_reset();
    mPtr = 1; mBusy = 32'h0; mErr = 1'b0;
    mRegWrite = 1'b0; mWriteReg = 5'd0; mWriteData = 32'h0;
  endtask

  // Which requester the rules say wins: 0 if WB valid, else first valid from mPtr, wrapping over 1..N-1.
  function automatic int model_grant(input logic [NUM_REQ-1:0] v);
    if (v[0]) return 0;
    for (int n = 0; n < NUM_REQ - 1; n++) begin
      int k;
      k = 1 + (mPtr - 1 + n) % (NUM_REQ - 1);
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_ready(input logic [NUM_REQ-1:0] v);
    int g;
    g = model_grant(v);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    int          g;
    logic [4:0]  a;
    logic [31:0] d;
    logic        cv;
    logic [4:0]  ca;
    g  = model_grant(req_valid);
    a  = 5'd0;
    d  = 32'h0;
    if (g >= 0) begin
      a = addrA[g];
      d = dataA[g];
    end
    cv = claim_valid;
    ca = claim_addr;
    @(posedge Clk);
    mRegWrite = (g >= 0) && (a != 5'd0);
    if (g >= 0) begin
      mWriteReg  = a;
      mWriteData = d;
    end
    if (g >= 1) begin
      mBusy[a] = 1'b0;
      mPtr = (g == NUM_REQ - 1) ? 1 : g + 1;
    end
    if (cv && ca != 5'd0) begin
      if (mBusy[ca]) mErr = 1'b1;
      mBusy[ca] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 3'b111;
    claim_valid = 1'b0; claim_addr = 5'd0;
    for (int i = 0; i < NUM_REQ; i++) begin addrA[i] = 5'd0; dataA[i] = 32'h0; end
    drive();
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    vecs++; if (req_ready !== 3'b000) begin miss++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
    vecs++; if (RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'h0) begin
      miss++; $display("FAIL reset_wport: got %b %0d %h expected 0 0 0", RegWrite, WriteReg, WriteData); end
    vecs++; if (busy_mask !== 32'h0 || claim_err !== 1'b0) begin
      miss++; $display("FAIL reset_sb: got %h %b expected 0 0", busy_mask, claim_err); end
    req_valid = 3'b000;
    @(negedge Clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_wb();
    addrA[0] = 5'd8; dataA[0] = 32'h1;
    req_valid = 3'b001;
    drive(); #1;
    vecs++; if (req_ready !== 3'b001) begin miss++; $display("FAIL basic_ready: got %b expected 001", req_ready); end
    tick();
    req_valid = 3'b000;
    vecs++; if (RegWrite !== 1'b1 || WriteReg !== 5'd8 || WriteData !== 32'h1) begin
      miss++; $display("FAIL basic_write: got %b %0d %h expected 1 8 1", RegWrite, WriteReg, WriteData); end
    tick();
    vecs++; if (RegWrite !== 1'b0 || WriteReg !== 5'd8 || WriteData !== 32'h1) begin
      miss++; $display("FAIL basic_hold: got %b %0d %h expected 0 8 1", RegWrite, WriteReg, WriteData); end
  endtask

  task automatic test_rr_order();
    addrA[0] = 5'd1; dataA[0] = 32'hA0;
    addrA[1] = 5'd2; dataA[1] = 32'hA1;
    addrA[2] = 5'd3; dataA[2] = 32'hA2;
    req_valid = 3'b111; drive(); #1;
    vecs++; if (req_ready !== 3'b001) begin miss++; $display("FAIL rr_first: got %b expected 001", req_ready); end
    tick();
    req_valid = 3'b110; #1;
    vecs++; if (req_ready !== 3'b010) begin miss++; $display("FAIL rr_second: got %b expected 010", req_ready); end
    tick();
    vecs++; if (WriteReg !== 5'd2 || WriteData !== 32'hA1) begin
      miss++; $display("FAIL rr_second_data: got %0d %h expected 2 a1", WriteReg, WriteData); end
    req_valid = 3'b100; #1;
    vecs++; if (req_ready !== 3'b100) begin miss++; $display("FAIL rr_third: got %b expected 100", req_ready); end
    tick();
    req_valid = 3'b110; #1;
    vecs++; if (req_ready !== 3'b010) begin miss++; $display("FAIL rr_wrap: got %b expected 010", req_ready); end
    tick();
    req_valid = 3'b000;
  endtask

  task automatic test_scoreboard_clear();
    claim_valid = 1'b1; claim_addr = 5'd9;
    tick();
    claim_valid = 1'b0;
    vecs++; if (busy_mask[9] !== 1'b1) begin miss++; $display("FAIL sb_set: got %b expected 1", busy_mask[9]); end
    tick();
    addrA[1] = 5'd9; dataA[1] = 32'h0000_0999;
    req_valid = 3'b010; drive(); #1;
    vecs++; if (busy_mask[9] !== 1'b1 || req_ready !== 3'b010) begin
      miss++; $display("FAIL sb_pre_clear: got busy=%b ready=%b expected 1 010", busy_mask[9], req_ready); end
    tick();
    req_valid = 3'b000;
    vecs++; if (busy_mask[9] !== 1'b0 || RegWrite !== 1'b1 || WriteReg !== 5'd9) begin
      miss++; $display("FAIL sb_clear: got busy=%b we=%b reg=%0d expected 0 1 9", busy_mask[9], RegWrite, WriteReg); end
  endtask

  task automatic test_set_wins();
    claim_valid = 1'b1; claim_addr = 5'd10;
    tick();
    addrA[2] = 5'd10; dataA[2] = 32'h0000_1010;
    req_valid = 3'b100; drive();
    tick();
    claim_valid = 1'b0; req_valid = 3'b000;
    vecs++; if (busy_mask[10] !== 1'b1 || RegWrite !== 1'b1 || WriteReg !== 5'd10 || claim_err !== 1'b0) begin
      miss++; $display("FAIL set_wins: got busy=%b we=%b reg=%0d err=%b expected 1 1 10 0",
                       busy_mask[10], RegWrite, WriteReg, claim_err); end
  endtask

  task automatic test_addr_zero();
    addrA[1] = 5'd0; dataA[1] = 32'hDEAD_0000;
    req_valid = 3'b010; claim_valid = 1'b1; claim_addr = 5'd0;
    drive(); #1;
    vecs++; if (req_ready !== 3'b010) begin miss++; $display("FAIL zero_ready: got %b expected 010", req_ready); end
    tick();
    req_valid = 3'b000; claim_valid = 1'b0;
    vecs++; if (RegWrite !== 1'b0) begin miss++; $display("FAIL zero_we: got %b expected 0", RegWrite); end
    vecs++; if (busy_mask !== 32'h0000_0400) begin miss++; $display("FAIL zero_claim: got %h expected 00000400", busy_mask); end
  endtask

  task automatic test_reset_mid();
    claim_valid = 1'b1; claim_addr = 5'd9;
    tick();
    claim_valid = 1'b0;
    vecs++; if (busy_mask !== 32'h0000_0600) begin miss++; $display("FAIL mid_pre: got %h expected 00000600", busy_mask); end
    addrA[1] = 5'd4; dataA[1] = 32'h4444;
    addrA[2] = 5'd5; dataA[2] = 32'h5555;
    req_valid = 3'b110; drive();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    vecs++; if (req_ready !== 3'b000 || RegWrite !== 1'b0 || WriteReg !== 5'd0 || WriteData !== 32'h0 ||
                busy_mask !== 32'h0 || claim_err !== 1'b0) begin
      miss++; $display("FAIL mid_reset: got ready=%b we=%b reg=%0d data=%h busy=%h err=%b expected all 0",
                       req_ready, RegWrite, WriteReg, WriteData, busy_mask, claim_err); end
    @(negedge Clk);
    reset = 1'b0;
    #1;
    vecs++; if (req_ready !== 3'b010) begin miss++; $display("FAIL mid_restart: got %b expected 010", req_ready); end
    tick();
    req_valid = 3'b000;
    vecs++; if (WriteReg !== 5'd4 || WriteData !== 32'h4444) begin
      miss++; $display("FAIL mid_write: got %0d %h expected 4 4444", WriteReg, WriteData); end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] er;
    int g;
    pending = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pending[i] && $urandom_range(0, 99) < ((i == 0) ? 25 : 50)) begin
          pending[i] = 1'b1;
          addrA[i] = (i == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
          dataA[i] = $urandom;
        end
      end
      req_valid   = pending;
      claim_valid = ($urandom_range(0, 3) == 0);
      claim_addr  = 5'($urandom_range(0, 7));
      drive(); #1;
      er = exp_ready(req_valid);
      g  = model_grant(req_valid);
      vecs++; if (req_ready !== er) begin miss++; $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, req_ready, er); end
      tick();
      vecs++; if (RegWrite !== mRegWrite || WriteReg !== mWriteReg || WriteData !== mWriteData) begin
        miss++; $display("FAIL rand_wport cyc %0d: got %b %0d %h expected %b %0d %h",
                         cyc, RegWrite, WriteReg, WriteData, mRegWrite, mWriteReg, mWriteData); end
      vecs++; if (busy_mask !== mBusy || claim_err !== mErr) begin
        miss++; $display("FAIL rand_sb cyc %0d: got %h %b expected %h %b", cyc, busy_mask, claim_err, mBusy, mErr); end
      if (g >= 0) pending[g] = 1'b0;
    end
    req_valid = '0; claim_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_wb();
    test_rr_order();
    test_scoreboard_clear();
    test_set_wins();
    test_addr_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
